// File: rtl/core_seq_ctrl_pkg.sv
// Shared types and defaults for the core instruction sequencer.
package core_seq_ctrl_pkg;

  localparam int TO_W_DEF  = 8;
  localparam int CNT_W_DEF = 32;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_F_REQ  = 3'd1,
    ST_F_WAIT = 3'd2,
    ST_EXEC   = 3'd3,
    ST_M_REQ  = 3'd4,
    ST_M_WAIT = 3'd5,
    ST_HALT   = 3'd6,
    ST_ERR    = 3'd7
  } seq_state_e;

endpackage

// File: rtl/core_seq_ctrl_sat_cnt.sv
// Clear/increment counter that saturates at all-ones; used as the stall watchdog.
module sat_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count,
  output logic         at_max
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  assign at_max = (count_q == {W{1'b1}});
  assign count  = count_q;

  // Clear wins over increment so a state change always restarts the count.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && !at_max) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/core_seq_ctrl.sv
// Fetch/execute/memory sequencer driving the PC, IR and regfile-write enables,
// with a stall watchdog, sticky halt and an instructions-retired counter.
module core_seq_ctrl
  import core_seq_ctrl_pkg::*;
#(
  parameter int TO_W  = TO_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rstn,
  output logic             imem_req_valid,
  input  logic             imem_req_ready,
  input  logic             imem_rsp_valid,
  output logic             dmem_req_valid,
  input  logic             dmem_req_ready,
  input  logic             dmem_rsp_valid,
  input  logic             is_mem,
  input  logic             is_load,
  input  logic             halt_req,
  output logic             ir_en,
  output logic             pc_en,
  output logic             rf_we_en,
  output logic             halted,
  output logic             timeout_err,
  output logic [CNT_W-1:0] instret
);

  seq_state_e       state_q;
  seq_state_e       state_d;
  logic [CNT_W-1:0] instret_q;
  logic [CNT_W-1:0] instret_d;
  logic             wd_inc;
  logic             wd_clr;
  logic             wd_max;
  logic [TO_W-1:0]  wd_count;

  sat_cnt #(.W(TO_W)) u_watchdog (
    .clk    (clk),
    .rstn   (rstn),
    .clr    (wd_clr),
    .inc    (wd_inc),
    .count  (wd_count),
    .at_max (wd_max)
  );

  // An expired watchdog overrides any handshake finishing in the same cycle,
  // so the commit enables stay low on the way into ERR.
  always_comb begin
    state_d        = state_q;
    imem_req_valid = 1'b0;
    dmem_req_valid = 1'b0;
    ir_en          = 1'b0;
    pc_en          = 1'b0;
    rf_we_en       = 1'b0;
    halted         = 1'b0;
    timeout_err    = 1'b0;
    wd_inc         = 1'b0;
    case (state_q)
      ST_IDLE: state_d = ST_F_REQ;
      ST_F_REQ: begin
        imem_req_valid = 1'b1;
        wd_inc         = 1'b1;
        if (wd_max)              state_d = ST_ERR;
        else if (imem_req_ready) state_d = ST_F_WAIT;
      end
      ST_F_WAIT: begin
        wd_inc = 1'b1;
        if (wd_max) begin
          state_d = ST_ERR;
        end else if (imem_rsp_valid) begin
          ir_en   = 1'b1;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (halt_req) begin
          state_d = ST_HALT;
        end else if (is_mem) begin
          state_d = ST_M_REQ;
        end else begin
          pc_en    = 1'b1;
          rf_we_en = 1'b1;
          state_d  = ST_F_REQ;
        end
      end
      ST_M_REQ: begin
        dmem_req_valid = 1'b1;
        wd_inc         = 1'b1;
        if (wd_max)              state_d = ST_ERR;
        else if (dmem_req_ready) state_d = ST_M_WAIT;
      end
      ST_M_WAIT: begin
        wd_inc = 1'b1;
        if (wd_max) begin
          state_d = ST_ERR;
        end else if (dmem_rsp_valid) begin
          pc_en    = 1'b1;
          rf_we_en = is_load;
          state_d  = ST_F_REQ;
        end
      end
      ST_HALT: halted      = 1'b1;
      ST_ERR:  timeout_err = 1'b1;
      default: state_d = ST_IDLE;
    endcase
  end

  assign wd_clr    = (state_d != state_q);
  assign instret_d = instret_q + {{(CNT_W-1){1'b0}}, pc_en};
  assign instret   = instret_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= ST_IDLE;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
    end
  end

endmodule

// File: tb/tb_core_seq_ctrl.sv
// Randomized bench: plays both memories and the decoder, predicting every output per cycle.
module tb_core_seq_ctrl;

  localparam int TO_W  = 4;
  localparam int CNT_W = 4;

  localparam logic [6:0] F_IMEM = 7'b1000000;
  localparam logic [6:0] F_DMEM = 7'b0100000;
  localparam logic [6:0] F_IR   = 7'b0010000;
  localparam logic [6:0] F_PC   = 7'b0001000;
  localparam logic [6:0] F_RF   = 7'b0000100;
  localparam logic [6:0] F_HALT = 7'b0000010;
  localparam logic [6:0] F_TO   = 7'b0000001;

  localparam int K_ALU = 0, K_LOAD = 1, K_STORE = 2, K_HALT = 3;
  localparam int END_NORMAL = 0, END_RESET = 1, END_TIMEOUT = 2;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             imem_req_valid, imem_req_ready, imem_rsp_valid;
  logic             dmem_req_valid, dmem_req_ready, dmem_rsp_valid;
  logic             is_mem, is_load, halt_req;
  logic             ir_en, pc_en, rf_we_en, halted, timeout_err;
  logic [CNT_W-1:0] instret;

  int checks   = 0;
  int failures = 0;
  int retired  = 0;

  always #5 clk = ~clk;

  core_seq_ctrl #(.TO_W(TO_W), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rstn           (rstn),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .dmem_req_valid (dmem_req_valid),
    .dmem_req_ready (dmem_req_ready),
    .dmem_rsp_valid (dmem_rsp_valid),
    .is_mem         (is_mem),
    .is_load        (is_load),
    .halt_req       (halt_req),
    .ir_en          (ir_en),
    .pc_en          (pc_en),
    .rf_we_en       (rf_we_en),
    .halted         (halted),
    .timeout_err    (timeout_err),
    .instret        (instret)
  );

  function automatic logic rb();
    return logic'($urandom_range(0, 1));
  endfunction

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s at %0t: got flags=%b instret=%0d, want flags=%b instret=%0d",
               tag, $time, observed[10:4], observed[3:0], expected[10:4], expected[3:0]);
    end
  endtask

  // One clock cycle: drive inputs after the falling edge, then compare all outputs
  // (flags in order imem_req, dmem_req, ir_en, pc_en, rf_we_en, halted, timeout_err).
  task automatic applyStimulus(input string tag, input logic irdy, input logic irsp,
                               input logic drdy, input logic drsp, input logic mem,
                               input logic load, input logic hlt, input logic [6:0] exp_flags);
    logic [3:0] exp_cnt;
    @(negedge clk);
    imem_req_ready = irdy;
    imem_rsp_valid = irsp;
    dmem_req_ready = drdy;
    dmem_rsp_valid = drsp;
    is_mem         = mem;
    is_load        = load;
    halt_req       = hlt;
    #1;
    exp_cnt = 4'(retired % 16);
    checkOutput(tag,
                {5'd0, imem_req_valid, dmem_req_valid, ir_en, pc_en, rf_we_en, halted, timeout_err, instret},
                {5'd0, exp_flags, exp_cnt});
    if ((exp_flags & F_PC) != 7'd0) retired++;
  endtask

  task automatic doReset();
    @(negedge clk);
    rstn           = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    dmem_req_ready = 1'b0;
    dmem_rsp_valid = 1'b0;
    is_mem         = 1'b0;
    is_load        = 1'b0;
    halt_req       = 1'b0;
    @(posedge clk);
    #1;
    rstn    = 1'b1;
    retired = 0;
    applyStimulus("idle", rb(), rb(), rb(), rb(), rb(), rb(), rb(), 7'd0);
  endtask

  // Whole instruction: a/b = imem ready/rsp wait cycles, c/d = dmem ready/rsp wait cycles.
  task automatic runInstr(input int kind, input int a, input int b, input int c, input int d,
                          input int ending);
    logic ld;
    ld = (kind == K_LOAD);
    for (int i = 0; i <= a; i++)
      applyStimulus("fetch_req", i == a, rb(), rb(), rb(), rb(), rb(), rb(), F_IMEM);
    for (int i = 0; i <= b; i++)
      applyStimulus("fetch_wait", rb(), i == b, rb(), rb(), rb(), rb(), rb(), (i == b) ? F_IR : 7'd0);
    case (kind)
      K_HALT: begin
        applyStimulus("exec_halt", rb(), rb(), rb(), rb(), 1'b1, rb(), 1'b1, 7'd0);
        return;
      end
      K_ALU: begin
        applyStimulus("exec_alu", rb(), rb(), rb(), rb(), 1'b0, rb(), 1'b0, F_PC | F_RF);
        return;
      end
      default: applyStimulus("exec_mem", rb(), rb(), rb(), rb(), 1'b1, ld, 1'b0, 7'd0);
    endcase
    for (int i = 0; i <= c; i++)
      applyStimulus("mem_req", rb(), rb(), i == c, 1'b0, rb(), ld, rb(), F_DMEM);
    if (ending == END_RESET) begin
      for (int i = 0; i < 2; i++)
        applyStimulus("mem_wait_abort", rb(), rb(), rb(), 1'b0, rb(), ld, rb(), 7'd0);
    end else if (ending == END_TIMEOUT) begin
      for (int i = 0; i < 16; i++)
        applyStimulus("mem_wait_to", rb(), rb(), rb(), i == 15, rb(), ld, rb(), 7'd0);
    end else begin
      for (int i = 0; i <= d; i++)
        applyStimulus("mem_wait", rb(), rb(), rb(), i == d, rb(), ld, rb(),
                      (i == d) ? (F_PC | (ld ? F_RF : 7'd0)) : 7'd0);
    end
  endtask

  initial begin
    $display("[TB] start");
    doReset();

    // Zero-wait ALU stream, then a slow load and a store.
    for (int n = 0; n < 4; n++) runInstr(K_ALU, 0, 0, 0, 0, END_NORMAL);
    runInstr(K_LOAD, 0, 0, 2, 3, END_NORMAL);
    runInstr(K_STORE, 1, 2, 0, 0, END_NORMAL);

    // Counter wrap: 17 ALU instructions from reset.
    doReset();
    for (int n = 0; n < 17; n++) runInstr(K_ALU, 0, 0, 0, 0, END_NORMAL);
    applyStimulus("wrap", 1'b0, rb(), rb(), rb(), rb(), rb(), rb(), F_IMEM);

    // Random instruction mix with random memory latencies.
    for (int n = 0; n < 40; n++)
      runInstr(int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
               int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), END_NORMAL);

    // Halt wins over is_mem and is sticky.
    runInstr(K_HALT, 1, 1, 0, 0, END_NORMAL);
    for (int i = 0; i < 6; i++)
      applyStimulus("halted", rb(), rb(), rb(), rb(), rb(), rb(), rb(), F_HALT);

    // Fetch response never arrives; a late one on the expiry cycle must be ignored.
    doReset();
    runInstr(K_ALU, 0, 0, 0, 0, END_NORMAL);
    applyStimulus("to_freq", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, F_IMEM);
    for (int i = 0; i < 16; i++)
      applyStimulus("to_fwait", rb(), i == 15, rb(), rb(), rb(), rb(), rb(), 7'd0);
    for (int i = 0; i < 5; i++)
      applyStimulus("err", rb(), 1'b1, rb(), 1'b1, rb(), rb(), rb(), F_TO);

    // Data response lost: watchdog expiry in M_WAIT suppresses the commit.
    doReset();
    runInstr(K_LOAD, 0, 0, 0, 15, END_TIMEOUT);
    for (int i = 0; i < 3; i++)
      applyStimulus("err_mem", rb(), rb(), rb(), 1'b1, rb(), rb(), rb(), F_TO);

    // Reset during M_WAIT abandons the load.
    doReset();
    runInstr(K_ALU, 0, 0, 0, 0, END_NORMAL);
    runInstr(K_LOAD, 1, 0, 1, 0, END_RESET);
    doReset();
    applyStimulus("after_reset", 1'b0, rb(), rb(), rb(), rb(), rb(), rb(), F_IMEM);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
